wb_sdram_bridge: RTL and testbench

Wishbone slave front end for the SDRAM controller user port, replacing the fixed two-window code/data glue with a parametrised region decoder and bank remapper. It adds a posted-write FIFO so writes are acknowledged without waiting for the controller, a single outstanding read engine with timeout, and error responses for unmapped addresses. It sits between the user-area Wishbone bus and sdram_controller.

---
 rtl/wb_sdram_bridge.sv | 244 ++++++++++++++++++++++++
 tb/tb_wb_sdram_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_bridge.sv
// wb_sdram_bridge
//   Wishbone slave front end for the sdram_controller user port.
//   - Decodes adr[31:24] against N_REGIONS prefixes; the lowest matching
//     region wins. Unmapped addresses get a one-cycle err pulse.
//   - Remaps each region onto its own share of the four SDRAM banks.
//   - Posts writes into a small FIFO and acks them straight away. The FIFO
//     drains to the controller whenever no read is in flight.
//   - Runs one read at a time, and only once the FIFO is empty, so a read
//     always sees earlier writes. A read that gets no data within
//     RD_TIMEOUT cycles ends with err and returns zero data.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wbs_stb_i .. wbs_dat_i        Wishbone slave request side
//   wbs_ack_o, wbs_err_o          single-cycle response pulses
//   wbs_dat_o                     read data, held until the next read completes
//   ctrl_addr .. ctrl_in_valid    controller request (held while ctrl_busy)
//   ctrl_busy                     controller back-pressure
//   ctrl_rdata, ctrl_out_valid    controller read return
//   wfifo_level                   posted-write FIFO occupancy
module wb_sdram_bridge #(
  parameter int                     N_REGIONS     = 2,
  parameter logic [N_REGIONS*8-1:0] REGION_PREFIX = {8'h38, 8'h30},
  parameter int                     ADDR_W        = 23,
  parameter int                     WFIFO_DEPTH   = 4,
  parameter int                     RD_TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_we_i,
  input  logic [3:0]                     wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [31:0]                    wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic                           wbs_err_o,
  output logic [31:0]                    wbs_dat_o,
  output logic [ADDR_W-1:0]              ctrl_addr,
  output logic                           ctrl_rw,
  output logic [31:0]                    ctrl_wdata,
  output logic [3:0]                     ctrl_wmask,
  output logic                           ctrl_in_valid,
  input  logic                           ctrl_busy,
  input  logic [31:0]                    ctrl_rdata,
  input  logic                           ctrl_out_valid,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level
);

  localparam int PTR_W     = $clog2(WFIFO_DEPTH);
  localparam int CNT_W     = $clog2(RD_TIMEOUT + 1);
  localparam int BANKS_PER = 4 / N_REGIONS;
  localparam int ENTRY_W   = ADDR_W + 32 + 4;

  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(WFIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RESP} state_t;

  state_t state_reg, state_next;

  // ---------------- address decode and bank remap ----------------
  logic [N_REGIONS-1:0] hit_vec;
  logic                 hit;
  logic [1:0]           region;
  logic [1:0]           bank;
  logic [ADDR_W-1:0]    map_addr;
  logic                 unused_adr;

  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
      assign hit_vec[gi] = (wbs_adr_i[31:24] == REGION_PREFIX[gi*8 +: 8]);
    end
  endgenerate

  // Scan from the top so the lowest matching region is written last.
  always_comb begin
    hit    = 1'b0;
    region = 2'd0;
    for (int r = N_REGIONS - 1; r >= 0; r--) begin
      if (hit_vec[r]) begin
        hit    = 1'b1;
        region = 2'(r);
      end
    end
  end

  // Each region owns BANKS_PER consecutive banks; adr[9:8] picks within them.
  assign bank     = 2'((int'(wbs_adr_i[9:8]) % BANKS_PER) + int'(region) * BANKS_PER);
  assign map_addr = ADDR_W'({wbs_adr_i[22:10], bank, wbs_adr_i[7:0]});
  assign unused_adr = wbs_adr_i[23];

  // ---------------- request qualification ----------------
  logic ack_reg, ack_next;
  logic err_reg, err_next;
  logic req, wr_hit_req, rd_hit_req, miss_req;

  // A cycle that already shows ack/err is the tail of the previous transfer.
  assign req        = wbs_stb_i & wbs_cyc_i & ~ack_reg & ~err_reg;
  assign wr_hit_req = req & hit & wbs_we_i;
  assign rd_hit_req = req & hit & ~wbs_we_i;
  assign miss_req   = req & ~hit;

  // ---------------- posted-write FIFO ----------------
  // The head entry drives the controller in the cycle it becomes valid, so
  // the storage is read asynchronously.
  logic [ENTRY_W-1:0] fifo_mem [WFIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     level_reg, level_next;
  logic [ENTRY_W-1:0] head;
  logic               full, push, pop, drain;

  assign full  = (level_reg == LVL_FULL);
  assign push  = wr_hit_req & ~full;
  assign drain = (level_reg != '0) && (state_reg == IDLE || state_reg == WR_ISSUE);
  assign pop   = drain & ~ctrl_busy;
  assign head  = fifo_mem[rd_ptr_reg];

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_ONE;
      2'b01:   level_next = level_reg - LVL_ONE;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {map_addr, wbs_dat_i, wbs_sel_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      level_reg <= level_next;
    end
  end

  // ---------------- control FSM ----------------
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [31:0]       dat_reg, dat_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rd_addr_reg <= '0;
      dat_reg     <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rd_addr_reg <= rd_addr_next;
      dat_reg     <= dat_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rd_addr_next = rd_addr_reg;
    dat_next     = dat_reg;
    ack_next     = push;
    err_next     = miss_req;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          // A single entry drained right here needs no trip through WR_ISSUE.
          if (level_next != '0) state_next = WR_ISSUE;
        end else if (rd_hit_req) begin
          state_next   = RD_ISSUE;
          rd_addr_next = map_addr;
        end
      end
      WR_ISSUE: begin
        if (level_next == '0) state_next = IDLE;
      end
      RD_ISSUE: begin
        if (!ctrl_busy) begin
          state_next = RD_WAIT;
          cnt_next   = '0;
        end
      end
      RD_WAIT: begin
        // Data arriving on the last allowed cycle still counts as success.
        if (ctrl_out_valid) begin
          state_next = RESP;
          ack_next   = 1'b1;
          dat_next   = ctrl_rdata;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RESP;
          err_next   = 1'b1;
          dat_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RESP: begin
        // ack/err is already showing this cycle; even after a master abort
        // the pulse is emitted and simply ignored by the bus.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    ctrl_in_valid = 1'b0;
    ctrl_rw       = 1'b0;
    ctrl_addr     = '0;
    ctrl_wdata    = '0;
    ctrl_wmask    = '0;
    if (drain) begin
      ctrl_in_valid = 1'b1;
      ctrl_rw       = 1'b1;
      ctrl_addr     = head[ENTRY_W-1 -: ADDR_W];
      ctrl_wdata    = head[35:4];
      ctrl_wmask    = head[3:0];
    end else if (state_reg == RD_ISSUE) begin
      ctrl_in_valid = 1'b1;
      ctrl_addr     = rd_addr_reg;
    end
  end

  assign wbs_ack_o   = ack_reg;
  assign wbs_err_o   = err_reg;
  assign wbs_dat_o   = dat_reg;
  assign wfifo_level = level_reg;

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Directed bench for wb_sdram_bridge: default 2-region instance plus a
// 4-region instance used for the decode table check.
module tb_wb_sdram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        wbs_stb_i = 0, wbs_cyc_i = 0, wbs_we_i = 0;
  logic [3:0]  wbs_sel_i = 0;
  logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbs_dat_o;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw, ctrl_in_valid;
  logic [31:0] ctrl_wdata;
  logic [3:0]  ctrl_wmask;
  logic        ctrl_busy = 0;
  logic [31:0] ctrl_rdata = 0;
  logic        ctrl_out_valid = 0;
  logic [2:0]  wfifo_level;

  wb_sdram_bridge dut (
    .clk(clk), .rst(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
    .ctrl_wmask(ctrl_wmask), .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
    .ctrl_rdata(ctrl_rdata), .ctrl_out_valid(ctrl_out_valid), .wfifo_level(wfifo_level)
  );

  // Second instance: four regions 0x30..0x33, controller permanently busy.
  logic        stb4 = 0, cyc4 = 0, we4 = 0;
  logic [3:0]  sel4 = 0;
  logic [31:0] adr4 = 0, dat4 = 0;
  logic        ack4, err4;
  logic [31:0] rdat4;
  logic [22:0] caddr4;
  logic        crw4, cvalid4;
  logic [31:0] cwdata4;
  logic [3:0]  cwmask4;
  logic [2:0]  level4;

  wb_sdram_bridge #(.N_REGIONS(4), .REGION_PREFIX({8'h33, 8'h32, 8'h31, 8'h30})) dut4 (
    .clk(clk), .rst(rst),
    .wbs_stb_i(stb4), .wbs_cyc_i(cyc4), .wbs_we_i(we4),
    .wbs_sel_i(sel4), .wbs_adr_i(adr4), .wbs_dat_i(dat4),
    .wbs_ack_o(ack4), .wbs_err_o(err4), .wbs_dat_o(rdat4),
    .ctrl_addr(caddr4), .ctrl_rw(crw4), .ctrl_wdata(cwdata4),
    .ctrl_wmask(cwmask4), .ctrl_in_valid(cvalid4), .ctrl_busy(1'b1),
    .ctrl_rdata(32'h0), .ctrl_out_valid(1'b0), .wfifo_level(level4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Controller model: logs every accepted request, answers reads after rd_lat cycles.
  typedef struct packed {
    logic        rw;
    logic [22:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ev_t;

  ev_t         log_q[$];
  int          rd_lat = 3;
  int          rd_cnt = 0;
  logic        rd_en  = 1'b1;
  logic [31:0] rd_val = 32'h0;

  always @(negedge clk) begin
    ctrl_out_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0 && rd_en) begin
        ctrl_out_valid = 1'b1;
        ctrl_rdata     = rd_val;
      end
    end
    if (!rst && ctrl_in_valid && !ctrl_busy) begin
      log_q.push_back('{ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_wmask});
      if (!ctrl_rw) rd_cnt = rd_lat;
    end
  end

  // One Wishbone transfer; cycles = number of cycles from request to ack/err.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic got_ack, output logic got_err,
                         output logic [31:0] rdat, output int cycles);
    @(posedge clk); #1;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    cycles = 0;
    while (cycles < 2000) begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) break;
      cycles++;
    end
    got_ack = wbs_ack_o;
    got_err = wbs_err_o;
    rdat    = wbs_dat_o;
    $display("xfer we=%0d adr=%08h wdat=%08h ack=%0d err=%0d rdat=%08h cycles=%0d",
             we, adr, dat, got_ack, got_err, rdat, cycles);
    @(posedge clk); #1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_xfer4(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          output logic got_ack, output logic got_err);
    int k;
    @(posedge clk); #1;
    stb4 = 1; cyc4 = 1; we4 = we; adr4 = adr; dat4 = dat; sel4 = 4'hF;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (ack4 || err4) break;
      k++;
    end
    got_ack = ack4;
    got_err = err4;
    $display("xfer4 we=%0d adr=%08h ack=%0d err=%0d", we, adr, got_ack, got_err);
    @(posedge clk); #1;
    stb4 = 0; cyc4 = 0; we4 = 0;
  endtask

  logic        a, e, a5, e5;
  logic [31:0] d, d5;
  int          c, c5, base;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_ack", wbs_ack_o, 0);
    check("rst_err", wbs_err_o, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_valid", ctrl_in_valid, 0);
    check("rst_addr", ctrl_addr, 0);
    check("rst_level", wfifo_level, 0);

    // Single posted write.
    wb_xfer(1, 32'h3000_0104, 32'hDEAD_BEEF, 4'hF, a, e, d, c);
    check("w1_ack", a, 1);
    check("w1_lat", c, 1);
    repeat (3) @(negedge clk);
    check("w1_count", log_q.size(), 1);
    check("w1_rw", log_q[0].rw, 1);
    check("w1_addr", log_q[0].addr, 23'h000104);
    check("w1_data", log_q[0].data, 32'hDEAD_BEEF);
    check("w1_mask", log_q[0].mask, 4'hF);

    // Read from region 1: bank 2, 3-cycle controller latency.
    rd_val = 32'h1234_5678;
    wb_xfer(0, 32'h3800_0004, 32'h0, 4'hF, a, e, d, c);
    check("r1_ack", a, 1);
    check("r1_lat", c, 5);
    check("r1_data", d, 32'h1234_5678);
    check("r1_count", log_q.size(), 2);
    check("r1_rw", log_q[1].rw, 0);
    check("r1_addr", log_q[1].addr, 23'h000204);
    check("r1_mask", log_q[1].mask, 0);

    // Fill the FIFO with the controller busy; the fifth write stalls.
    ctrl_busy = 1;
    base = log_q.size();
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1, 32'h3000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'(1 << i), a, e, d, c);
      check("fill_ack", a, 1);
      check("fill_lat", c, 1);
    end
    @(negedge clk);
    check("fill_level", wfifo_level, 4);
    fork
      wb_xfer(1, 32'h3000_0110, 32'hA000_0004, 4'h3, a5, e5, d5, c5);
      begin
        repeat (8) @(negedge clk);
        check("full_level", wfifo_level, 4);
        check("full_noack", wbs_ack_o, 0);
        check("full_noissue", log_q.size(), base);
        @(posedge clk); #1 ctrl_busy = 0;
      end
    join
    check("w5_ack", a5, 1);
    check("w5_lat", c5, 10);
    for (int k = 0; k < 50 && wfifo_level != 0; k++) @(negedge clk);
    check("drain_level", wfifo_level, 0);
    check("drain_count", log_q.size(), base + 5);
    for (int i = 0; i < 5; i++) begin
      check("drain_addr", log_q[base+i].addr, 23'h000100 + 23'(4 * i));
      check("drain_data", log_q[base+i].data, 32'hA000_0000 + 32'(i));
      check("drain_mask", log_q[base+i].mask, (i < 4) ? 4'(1 << i) : 4'h3);
    end

    // Write then read of the same address: the read waits for the drain.
    ctrl_busy = 1;
    base = log_q.size();
    rd_val = 32'h5A5A_0001;
    wb_xfer(1, 32'h3000_1310, 32'hCAFE_F00D, 4'hF, a, e, d, c);
    check("raw_wack", a, 1);
    fork
      wb_xfer(0, 32'h3000_1310, 32'h0, 4'hF, a5, e5, d5, c5);
      begin
        repeat (6) @(negedge clk);
        check("raw_noissue", log_q.size(), base);
        check("raw_head", {ctrl_in_valid, ctrl_rw}, 2'b11);
        @(posedge clk); #1 ctrl_busy = 0;
      end
    join
    check("raw_rack", a5, 1);
    check("raw_rdata", d5, 32'h5A5A_0001);
    check("raw_count", log_q.size(), base + 2);
    check("raw_first", {log_q[base].rw, log_q[base].addr}, {1'b1, 23'h001110});
    check("raw_second", {log_q[base+1].rw, log_q[base+1].addr}, {1'b0, 23'h001110});

    // Unmapped accesses.
    base = log_q.size();
    wb_xfer(1, 32'h2000_0000, 32'h1, 4'hF, a, e, d, c);
    check("miss_err", e, 1);
    check("miss_ack", a, 0);
    check("miss_lat", c, 1);
    wb_xfer(0, 32'h3900_0000, 32'h0, 4'hF, a, e, d, c);
    check("miss_rd_err", e, 1);
    check("miss_hold", d, 32'h5A5A_0001);
    repeat (3) @(negedge clk);
    check("miss_noissue", log_q.size(), base);
    check("miss_level", wfifo_level, 0);

    // Read with no data: err RD_TIMEOUT+1 cycles after controller acceptance.
    rd_en = 0;
    wb_xfer(0, 32'h3800_0000, 32'h0, 4'hF, a, e, d, c);
    check("to_err", e, 1);
    check("to_ack", a, 0);
    check("to_lat", c, 257);
    check("to_data", d, 0);
    rd_en = 1;

    // Data on the last allowed cycle wins over the timeout.
    rd_lat = 255;
    rd_val = 32'h55AA_55AA;
    wb_xfer(0, 32'h3800_0008, 32'h0, 4'hF, a, e, d, c);
    check("edge_ack", a, 1);
    check("edge_err", e, 0);
    check("edge_lat", c, 257);
    check("edge_data", d, 32'h55AA_55AA);
    rd_lat = 3;

    // Reset while writes are waiting to drain.
    ctrl_busy = 1;
    base = log_q.size();
    wb_xfer(1, 32'h3000_0000, 32'h0000_0011, 4'hF, a, e, d, c);
    wb_xfer(1, 32'h3000_0004, 32'h0000_0022, 4'hF, a, e, d, c);
    @(negedge clk);
    check("prerst_level", wfifo_level, 2);
    check("prerst_valid", ctrl_in_valid, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("mrst_level", wfifo_level, 0);
    check("mrst_valid", ctrl_in_valid, 0);
    check("mrst_addr", ctrl_addr, 0);
    check("mrst_wdata", ctrl_wdata, 0);
    check("mrst_wmask", ctrl_wmask, 0);
    check("mrst_ack", wbs_ack_o, 0);
    check("mrst_dat", wbs_dat_o, 0);
    ctrl_busy = 0;
    repeat (4) @(negedge clk);
    check("mrst_discard", log_q.size(), base);

    // Four-region decode.
    wb_xfer4(1, 32'h3300_0300, 32'h1111_2222, a, e);
    check("r4_ack", a, 1);
    @(negedge clk);
    check("r4_addr", caddr4, 23'h000300);
    check("r4_data", cwdata4, 32'h1111_2222);
    check("r4_valid", cvalid4, 1);
    wb_xfer4(1, 32'h3800_0000, 32'h0, a, e);
    check("r4_miss", e, 1);
    @(negedge clk);
    check("r4_level", level4, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
